// File: rtl/memaccess_seq.sv
// memaccess_seq: self-sequencing LC3 MemAccess stage with a valid/ack dmem port.
// Define MEMACCESS_TIMEOUT_EN to abort accesses left un-acked for TIMEOUT_CYC.
module memaccess_seq #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              mem_op,
  input  logic              m_control,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] memout,
  output logic [1:0]        mem_state,
  output logic              dmem_req,
  output logic              dmem_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_dout,
  output logic              err
);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_IND   = 2'd1,
    S_WRITE = 2'd2,
    S_IDLE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              done_q, done_d;
  logic              busy_w;
  logic              abort_w;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  assign busy_w = (state_q != S_IDLE);

`ifdef MEMACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    abort_w = busy_w && !dmem_ack &&
              (cnt_inc == CW'(TIMEOUT_CYC));
    cnt_d   = '0;
    if (busy_w && !dmem_ack && !abort_w) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort_w;
    end
  end

  assign err = err_q;
`else
  assign abort_w = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    memout_d = memout_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d   = mem_op;
          addr_d = m_addr;
          data_d = m_data;
          if (m_control) begin
            state_d = S_IND;
          end else if (mem_op) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_IND: begin
        if (dmem_ack) begin
          // pointer word becomes the effective address
          addr_d  = ADDR_W'(dmem_dout);
          state_d = op_q ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (dmem_ack) begin
          memout_d = dmem_dout;
          state_d  = S_IDLE;
          done_d   = 1'b1;
        end
      end
      S_WRITE: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    if (abort_w) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      addr_d   = addr_q;
      memout_d = memout_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      memout_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      memout_q <= memout_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_w;
  assign done      = done_q;
  assign memout    = memout_q;
  assign mem_state = state_q;
  assign dmem_req  = busy_w;
  assign dmem_rd   = (state_q == S_READ) ||
                     (state_q == S_IND);
  assign dmem_addr = addr_q;
  assign dmem_din  = data_q;

endmodule

// File: doc/memaccess_seq.md
Name: memaccess_seq

Overview:
- Parametrised, self-sequencing successor to the LC3 MemAccess stage.
- Accepts one load/store command from the controller and supports direct and indirect (LDI/STI) addressing.
- Drives a data-memory port that uses a valid/ack handshake, so memory latency is variable.
- Reports busy and done to the controller, and keeps the LC3 mem_state encoding visible for the existing bench/monitor.

Parameters:
- DATA_W, 16, data width of m_data, memout and the data-memory buses.
- ADDR_W, 16, address width of m_addr and dmem_addr.
- TIMEOUT_CYC, 255, cycles a dmem_req may stay un-acked before abort; used only with MEMACCESS_TIMEOUT_EN.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  command strobe from the controller; sampled only in IDLE.
- mem_op  in  1  0 = read (load), 1 = write (store).
- m_control  in  1  1 = indirect: the first access fetches the effective address.
- m_addr  in  ADDR_W  command address.
- m_data  in  DATA_W  store data.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse after the command completes.
- memout  out  DATA_W  registered load result.
- mem_state  out  2  current state: 0 READ, 1 IND, 2 WRITE, 3 IDLE.
- dmem_req  out  1  memory access valid.
- dmem_rd  out  1  1 = read access, 0 = write access; meaningful only while dmem_req is high.
- dmem_addr  out  ADDR_W  memory address.
- dmem_din  out  DATA_W  memory write data.
- dmem_ack  in  1  memory completes the current access; ignored while dmem_req is low.
- dmem_dout  in  DATA_W  memory read data; valid while dmem_ack is high.
- err  out  1  timeout-abort pulse.

Behaviour:
- Reset (asynchronous, active-low), outputs while asserted:
  - state IDLE, mem_state 3.
  - busy, done, err, dmem_req, dmem_rd = 0.
  - memout, dmem_addr, dmem_din and all internal holding registers = 0.
  - Reset asserted mid-access aborts immediately. dmem_req drops asynchronously and no done is issued.
- Accepting a command:
  - In IDLE with req=1, the block latches mem_op, m_control, m_addr (into addr_q) and m_data (into data_q) at the clock edge.
  - Next state: IND if m_control=1; otherwise WRITE if mem_op=1, else READ.
  - req while busy is ignored. There is no queueing, and the controller must wait for done.
- Memory outputs are decoded from the state register and the holding registers only. They never depend on same-cycle inputs.
  - IND: dmem_req=1, dmem_rd=1, dmem_addr=addr_q.
  - READ: dmem_req=1, dmem_rd=1, dmem_addr=addr_q.
  - WRITE: dmem_req=1, dmem_rd=0, dmem_addr=addr_q, dmem_din=data_q.
  - IDLE: dmem_req=0; dmem_addr and dmem_din hold their last values.
- Each dmem_ack completes exactly one access. Wait cycles (dmem_req=1, ack=0) hold every output stable.
- Transitions on ack:
  - IND: addr_q <= dmem_dout resized to ADDR_W (low bits kept if ADDR_W<DATA_W, zero-extended if ADDR_W>DATA_W). Next state is WRITE if the latched op is write, else READ. dmem_req stays high and the address changes in the next cycle.
  - READ: memout <= dmem_dout; go to IDLE; done=1 in the following cycle.
  - WRITE: go to IDLE; done=1 in the following cycle. memout is unchanged.
- Latency with zero-wait memory (ack in the same cycle as req), measured from the req sample edge:
  - direct access: done 2 cycles later.
  - indirect access: done 3 cycles later.
  - each wait cycle adds 1.
- done is high in the first IDLE cycle. A new req in that same cycle is accepted, giving back-to-back commands.
- memout holds its value until the next successful read completes.

Optional Feature:
- Macro: MEMACCESS_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) increments on every cycle with dmem_req=1 and dmem_ack=0.
  - It clears on ack, when entering IDLE, and on reset.
  - When the count reaches TIMEOUT_CYC with no ack, the access aborts: state -> IDLE, then done=1 and err=1 together for one cycle.
  - memout and addr_q are not updated by an aborted access.
  - An ack arriving in the abort cycle wins: normal completion, no err.
- Undefined: no counter; the block waits indefinitely; err is tied to 0.

Test Plan:
- Reset with the FSM in READ and dmem_req=1 -> dmem_req falls without waiting for a clock edge; mem_state=3; memout=0; no done pulse.
- Direct load, m_addr=0x3000, memory returns 0xBEEF with 0 wait -> dmem_req=1, dmem_rd=1, dmem_addr=0x3000 for 1 cycle; memout=0xBEEF; done 2 cycles after the req edge.
- Direct store, m_addr=0x4010, m_data=0x1234, ack after 3 wait cycles -> dmem_rd=0, dmem_din=0x1234 held stable for 4 cycles; done 5 cycles after the req edge; memout unchanged.
- LDI, m_addr=0x3100, mem[0x3100]=0x5000, mem[0x5000]=0x00A5 -> mem_state sequence 3,1,0,3; second dmem_addr=0x5000; memout=0x00A5; done at +3. Repeat as STI with m_data=0x7777 -> write of 0x7777 to 0x5000.
- req pulsed while busy, then a new req in the done cycle -> the first req is ignored; the second is accepted with no idle gap.
- MEMACCESS_TIMEOUT_EN defined, TIMEOUT_CYC=4, ack never asserted -> abort after 4 wait cycles; done=err=1 for 1 cycle; memout unchanged. Undefined -> dmem_req stays high; err=0.
